// File: rtl/mem_bus_pkg.sv
// Shared types and default address map for the CPU memory bus controller.
package mem_bus_pkg;

  localparam int unsigned ADDR_W     = 16;
  localparam int unsigned GFX_ADDR_W = 14;
  localparam int unsigned WAIT_W     = 4;

  localparam logic [7:0]            GFX_LO_DEF   = 8'h80;
  localparam logic [7:0]            GFX_HI_DEF   = 8'h8A;
  localparam logic [ADDR_W-1:0]     KBD_ADDR_DEF = 16'hFE00;
  localparam logic [7:0]            ROM_PAGE     = 8'hFF;

  // Idle values parked on device address lines outside of ACCESS
  localparam logic [ADDR_W-1:0]     RAM_ADDR_IDLE = 16'hFFFF;
  localparam logic [ADDR_W-1:0]     ROM_ADDR_IDLE = 16'hFFFF;
  localparam logic [GFX_ADDR_W-1:0] GFX_ADDR_IDLE = 14'h3FFF;

  typedef enum logic [2:0] {
    REG_RAM,
    REG_KBD,
    REG_ROM,
    REG_GFX,
    REG_NONE
  } region_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_e;

  // Wait-state count for a region; keyboard and unmapped never wait
  function automatic logic [WAIT_W-1:0] region_wait(input region_e     region,
                                                   input int unsigned ram_w,
                                                   input int unsigned rom_w,
                                                   input int unsigned gfx_w);
    logic [WAIT_W-1:0] w;
    w = '0;
    case (region)
      REG_RAM: w = WAIT_W'(ram_w);
      REG_ROM: w = WAIT_W'(rom_w);
      REG_GFX: w = WAIT_W'(gfx_w);
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/addr_region_decode.sv
// Combinational virtual-address decoder: region select plus per-device translated addresses.
module addr_region_decode
  import mem_bus_pkg::*;
#(
  parameter logic [7:0]        GFX_LO   = GFX_LO_DEF,
  parameter logic [7:0]        GFX_HI   = GFX_HI_DEF,
  parameter logic [ADDR_W-1:0] KBD_ADDR = KBD_ADDR_DEF
) (
  input  logic [ADDR_W-1:0]     addr,
  output region_e               region_c,
  output logic [ADDR_W-1:0]     ram_addr_c,
  output logic [ADDR_W-1:0]     rom_addr_c,
  output logic [GFX_ADDR_W-1:0] gfx_addr_c
);

  logic [7:0] page;

  assign page = addr[15:8];

  // Priority decode, first match wins
  always_comb begin
    region_c = REG_NONE;
    if (!addr[15]) begin
      region_c = REG_RAM;
    end else if (page == ROM_PAGE) begin
      region_c = REG_ROM;
    end else if ((page >= GFX_LO) && (page < GFX_HI)) begin
      region_c = REG_GFX;
    end else if (addr == KBD_ADDR) begin
      region_c = REG_KBD;
    end
  end

  // Address translation for each device view
  always_comb begin
    ram_addr_c = {1'b0, addr[15:1]};
    rom_addr_c = {8'h00, addr[7:0]};
    gfx_addr_c = addr[GFX_ADDR_W-1:0];
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Sequential CPU bus controller: decodes, applies wait states, drives devices, returns registered data.
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int unsigned       DATA_W   = 16,
  parameter int unsigned       RAM_WAIT = 1,
  parameter int unsigned       ROM_WAIT = 0,
  parameter int unsigned       GFX_WAIT = 0,
  parameter logic [7:0]        GFX_LO   = GFX_LO_DEF,
  parameter logic [7:0]        GFX_HI   = GFX_HI_DEF,
  parameter logic [ADDR_W-1:0] KBD_ADDR = KBD_ADDR_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_W-1:0]     cpu_addr,
  input  logic [DATA_W-1:0]     cpu_wdata,
  output logic                  cpu_ready,
  output logic                  cpu_err,
  output logic [DATA_W-1:0]     cpu_rdata,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [DATA_W-1:0]     ram_wdata,
  input  logic [DATA_W-1:0]     ram_rdata,
  output logic [ADDR_W-1:0]     rom_addr,
  input  logic [DATA_W-1:0]     rom_rdata,
  output logic [GFX_ADDR_W-1:0] gfx_addr,
  output logic                  gfx_we,
  output logic [DATA_W-1:0]     gfx_wdata,
  input  logic [DATA_W-1:0]     kbd_rdata,
  input  logic                  kbd_valid,
  output logic                  kbd_pop
);

  state_e                state_q, state_d;
  region_e               region_q, region_d;
  logic                  we_q, we_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic                  cpu_ready_q, cpu_ready_d;
  logic                  cpu_err_q, cpu_err_d;
  logic [DATA_W-1:0]     cpu_rdata_q, cpu_rdata_d;
  logic [ADDR_W-1:0]     ram_addr_q, ram_addr_d;
  logic                  ram_en_q, ram_en_d;
  logic                  ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]     rom_addr_q, rom_addr_d;
  logic [GFX_ADDR_W-1:0] gfx_addr_q, gfx_addr_d;
  logic                  gfx_we_q, gfx_we_d;
  logic                  kbd_pop_q, kbd_pop_d;

  region_e               dec_region;
  logic [ADDR_W-1:0]     dec_ram_addr;
  logic [ADDR_W-1:0]     dec_rom_addr;
  logic [GFX_ADDR_W-1:0] dec_gfx_addr;

  addr_region_decode #(
    .GFX_LO   (GFX_LO),
    .GFX_HI   (GFX_HI),
    .KBD_ADDR (KBD_ADDR)
  ) u_decode (
    .addr       (cpu_addr),
    .region_c   (dec_region),
    .ram_addr_c (dec_ram_addr),
    .rom_addr_c (dec_rom_addr),
    .gfx_addr_c (dec_gfx_addr)
  );

  // Next-state and registered-output logic; device outputs are set one cycle
  // ahead so they are valid exactly while the FSM sits in ACCESS
  always_comb begin
    state_d     = state_q;
    region_d    = region_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    wait_cnt_d  = wait_cnt_q;
    cpu_ready_d = 1'b0;
    cpu_err_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    ram_addr_d  = ram_addr_q;
    ram_en_d    = ram_en_q;
    ram_we_d    = 1'b0;
    rom_addr_d  = rom_addr_q;
    gfx_addr_d  = gfx_addr_q;
    gfx_we_d    = 1'b0;
    kbd_pop_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cpu_req) begin
          region_d = dec_region;
          we_d     = cpu_we;
          wdata_d  = cpu_wdata;
          if ((dec_region == REG_NONE) || ((dec_region == REG_ROM) && cpu_we)) begin
            state_d     = ST_RESP;
            cpu_ready_d = 1'b1;
            cpu_err_d   = 1'b1;
            cpu_rdata_d = '0;
          end else begin
            state_d    = ST_ACCESS;
            wait_cnt_d = region_wait(dec_region, RAM_WAIT, ROM_WAIT, GFX_WAIT);
            case (dec_region)
              REG_RAM: begin
                ram_addr_d = dec_ram_addr;
                ram_en_d   = 1'b1;
                ram_we_d   = cpu_we;
              end
              REG_ROM: rom_addr_d = dec_rom_addr;
              REG_GFX: begin
                gfx_addr_d = dec_gfx_addr;
                gfx_we_d   = cpu_we;
              end
              default: ;
            endcase
          end
        end
      end

      ST_ACCESS: begin
        if (wait_cnt_q != '0) begin
          wait_cnt_d = wait_cnt_q - WAIT_W'(1);
        end else begin
          state_d     = ST_RESP;
          cpu_ready_d = 1'b1;
          ram_addr_d  = RAM_ADDR_IDLE;
          ram_en_d    = 1'b0;
          rom_addr_d  = ROM_ADDR_IDLE;
          gfx_addr_d  = GFX_ADDR_IDLE;
          cpu_rdata_d = '0;
          if (!we_q) begin
            case (region_q)
              REG_RAM: cpu_rdata_d = ram_rdata;
              REG_ROM: cpu_rdata_d = rom_rdata;
              REG_KBD: begin
                if (kbd_valid) begin
                  cpu_rdata_d = kbd_rdata;
                  kbd_pop_d   = 1'b1;
                end
              end
              default: cpu_rdata_d = '0;
            endcase
          end
        end
      end

      ST_RESP: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      region_q    <= REG_NONE;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      wait_cnt_q  <= '0;
      cpu_ready_q <= 1'b0;
      cpu_err_q   <= 1'b0;
      cpu_rdata_q <= '0;
      ram_addr_q  <= RAM_ADDR_IDLE;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      rom_addr_q  <= ROM_ADDR_IDLE;
      gfx_addr_q  <= GFX_ADDR_IDLE;
      gfx_we_q    <= 1'b0;
      kbd_pop_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      region_q    <= region_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      wait_cnt_q  <= wait_cnt_d;
      cpu_ready_q <= cpu_ready_d;
      cpu_err_q   <= cpu_err_d;
      cpu_rdata_q <= cpu_rdata_d;
      ram_addr_q  <= ram_addr_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      rom_addr_q  <= rom_addr_d;
      gfx_addr_q  <= gfx_addr_d;
      gfx_we_q    <= gfx_we_d;
      kbd_pop_q   <= kbd_pop_d;
    end
  end

  assign cpu_ready = cpu_ready_q;
  assign cpu_err   = cpu_err_q;
  assign cpu_rdata = cpu_rdata_q;
  assign ram_addr  = ram_addr_q;
  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_wdata = wdata_q;
  assign rom_addr  = rom_addr_q;
  assign gfx_addr  = gfx_addr_q;
  assign gfx_we    = gfx_we_q;
  assign gfx_wdata = wdata_q;
  assign kbd_pop   = kbd_pop_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl: driver queues expectations, monitor checks each cpu_ready.
module tb_mem_bus_ctrl;

  logic        clk;
  logic        rst, rst3;
  logic        req, req3;
  logic        we;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] ram_rdata, rom_rdata, kbd_rdata;
  logic        kbd_valid;

  logic        cpu_ready, cpu_err, ram_en, ram_we, gfx_we, kbd_pop;
  logic [15:0] cpu_rdata, ram_addr, ram_wdata, rom_addr, gfx_wdata;
  logic [13:0] gfx_addr;

  logic        cpu_ready3, cpu_err3, ram_en3, ram_we3, gfx_we3, kbd_pop3;
  logic [15:0] cpu_rdata3, ram_addr3, ram_wdata3, rom_addr3, gfx_wdata3;
  logic [13:0] gfx_addr3;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    logic        pop;
    int          ready_cyc;
    int          kind;      // 0 none, 1 ram, 2 rom, 3 gfx address check
    logic [15:0] dev_addr;
    int          n_ram_we;
    int          n_gfx_we;
    logic [15:0] gfx_wd;
  } exp_t;

  exp_t exp_q[$];

  mem_bus_ctrl #(.RAM_WAIT(1)) dut (
    .clk(clk), .rst(rst), .cpu_req(req), .cpu_we(we), .cpu_addr(addr), .cpu_wdata(wdata),
    .cpu_ready(cpu_ready), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
    .ram_addr(ram_addr), .ram_en(ram_en), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .rom_addr(rom_addr), .rom_rdata(rom_rdata),
    .gfx_addr(gfx_addr), .gfx_we(gfx_we), .gfx_wdata(gfx_wdata),
    .kbd_rdata(kbd_rdata), .kbd_valid(kbd_valid), .kbd_pop(kbd_pop)
  );

  mem_bus_ctrl #(.RAM_WAIT(3)) dut3 (
    .clk(clk), .rst(rst3), .cpu_req(req3), .cpu_we(we), .cpu_addr(addr), .cpu_wdata(wdata),
    .cpu_ready(cpu_ready3), .cpu_err(cpu_err3), .cpu_rdata(cpu_rdata3),
    .ram_addr(ram_addr3), .ram_en(ram_en3), .ram_we(ram_we3), .ram_wdata(ram_wdata3),
    .ram_rdata(ram_rdata), .rom_addr(rom_addr3), .rom_rdata(rom_rdata),
    .gfx_addr(gfx_addr3), .gfx_we(gfx_we3), .gfx_wdata(gfx_wdata3),
    .kbd_rdata(kbd_rdata), .kbd_valid(kbd_valid), .kbd_pop(kbd_pop3)
  );

  // ROM contents: C000 xor word address
  assign rom_rdata = 16'hC000 ^ rom_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: accumulate device activity, check it all when cpu_ready pulses
  int          m_ram_we = 0, m_gfx_we = 0;
  logic [15:0] m_ram_seen = 16'hFFFF, m_rom_seen = 16'hFFFF, m_gfx_seen = 16'h3FFF;
  logic [15:0] m_gfx_wd = 16'h0000;

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (ram_we === 1'b1) m_ram_we++;
      if (gfx_we === 1'b1) begin
        m_gfx_we++;
        m_gfx_wd = gfx_wdata;
      end
      if (ram_en === 1'b1) m_ram_seen = ram_addr;
      if (rom_addr !== 16'hFFFF) m_rom_seen = rom_addr;
      if (gfx_addr !== 14'h3FFF) m_gfx_seen = {2'b00, gfx_addr};
      if (kbd_pop === 1'b1 && cpu_ready !== 1'b1) chk("stray_kbd_pop", 32'(kbd_pop), 32'd0);
      if (cpu_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ready", 32'(cpu_ready), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("ready_cycle", 32'(cyc), 32'(e.ready_cyc));
          chk("cpu_rdata", 32'(cpu_rdata), 32'(e.rdata));
          chk("cpu_err", 32'(cpu_err), 32'(e.err));
          chk("kbd_pop", 32'(kbd_pop), 32'(e.pop));
          chk("ram_we_pulses", 32'(m_ram_we), 32'(e.n_ram_we));
          chk("gfx_we_pulses", 32'(m_gfx_we), 32'(e.n_gfx_we));
          if (e.n_gfx_we > 0) chk("gfx_wdata", 32'(m_gfx_wd), 32'(e.gfx_wd));
          case (e.kind)
            1: chk("ram_addr", 32'(m_ram_seen), 32'(e.dev_addr));
            2: chk("rom_addr", 32'(m_rom_seen), 32'(e.dev_addr));
            3: chk("gfx_addr", 32'(m_gfx_seen), 32'(e.dev_addr));
            default: ;
          endcase
          chk("idle_addrs_in_resp", {ram_addr, rom_addr}, 32'hFFFF_FFFF);
          chk("idle_gfx_en_in_resp", {15'd0, ram_en, 2'b00, gfx_addr}, 32'h0000_3FFF);
        end
        m_ram_we   = 0;
        m_gfx_we   = 0;
        m_ram_seen = 16'hFFFF;
        m_rom_seen = 16'hFFFF;
        m_gfx_seen = 16'h3FFF;
      end
    end
  end

  // Driver state: set when the previous call left req high through RESP
  logic in_resp = 1'b0;

  // Issue one transaction on the main DUT at the current negedge
  task automatic txn(input logic t_we, input logic [15:0] t_addr, input logic [15:0] t_wdata,
                     input logic [15:0] e_rdata, input logic e_err, input logic e_pop,
                     input int lat, input int kind, input logic [15:0] dev,
                     input int n_rw, input int n_gw, input logic keep);
    exp_t e;
    bit   seen;
    e.rdata     = e_rdata;
    e.err       = e_err;
    e.pop       = e_pop;
    e.ready_cyc = cyc + lat + (in_resp ? 1 : 0);
    e.kind      = kind;
    e.dev_addr  = dev;
    e.n_ram_we  = n_rw;
    e.n_gfx_we  = n_gw;
    e.gfx_wd    = t_wdata;
    exp_q.push_back(e);
    req   = 1'b1;
    we    = t_we;
    addr  = t_addr;
    wdata = t_wdata;
    seen  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cpu_ready === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("ready_timeout", 32'd0, 32'd1);
    if (keep) begin
      in_resp = 1'b1;
    end else begin
      in_resp = 1'b0;
      req     = 1'b0;
      @(negedge clk);
    end
  endtask

  // Reset mid-ACCESS on the RAM_WAIT=3 instance, then a clean transaction
  task automatic reset_test();
    bit seen;
    ram_rdata = 16'h1357;
    we        = 1'b0;
    addr      = 16'h0010;
    req3      = 1'b1;
    @(negedge clk);                       // cycle 1: ACCESS
    chk("rst3_access_ram_addr", 32'(ram_addr3), 32'h0008);
    chk("rst3_access_ram_en", 32'(ram_en3), 32'd1);
    rst3 = 1'b1;
    req3 = 1'b0;
    @(negedge clk);                       // reset taken on the edge just passed
    chk("rst3_ready", 32'(cpu_ready3), 32'd0);
    chk("rst3_addrs", {ram_addr3, rom_addr3}, 32'hFFFF_FFFF);
    chk("rst3_gfx_addr", 32'(gfx_addr3), 32'h3FFF);
    chk("rst3_strobes", {27'd0, ram_en3, ram_we3, gfx_we3, kbd_pop3, cpu_err3}, 32'd0);
    chk("rst3_rdata", 32'(cpu_rdata3), 32'd0);
    rst3 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (cpu_ready3 === 1'b1 || ram_en3 === 1'b1) seen = 1'b1;
    end
    chk("rst3_dropped_txn", 32'(seen), 32'd0);
    // fresh read of 0x0020: expect ready at cycle 3+2 = 5
    addr = 16'h0020;
    req3 = 1'b1;
    seen = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) chk("rst3_next_ram_addr", 32'(ram_addr3), 32'h0010);
      if (cpu_ready3 === 1'b1) begin
        seen = 1'b1;
        chk("rst3_next_latency", 32'(i), 32'd5);
        chk("rst3_next_rdata", 32'(cpu_rdata3), 32'h1357);
        chk("rst3_next_err", 32'(cpu_err3), 32'd0);
        break;
      end
    end
    if (!seen) chk("rst3_next_timeout", 32'd0, 32'd1);
    req3 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; rst3 = 1'b1;
    req = 1'b0; req3 = 1'b0; we = 1'b0;
    addr = 16'h0000; wdata = 16'h0000;
    ram_rdata = 16'h0000; kbd_rdata = 16'h0000; kbd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {26'd0, cpu_ready, cpu_err, ram_en, ram_we, gfx_we, kbd_pop}, 32'd0);
    chk("reset_rdata", 32'(cpu_rdata), 32'd0);
    chk("reset_addrs", {ram_addr, rom_addr}, 32'hFFFF_FFFF);
    chk("reset_gfx_addr", 32'(gfx_addr), 32'h3FFF);
    rst = 1'b0; rst3 = 1'b0;
    @(negedge clk);

    // we, addr, wdata, exp_rdata, err, pop, lat, kind, dev, ram_we#, gfx_we#, keep
    ram_rdata = 16'hBEEF;
    txn(1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 1'b0, 3, 1, 16'h0008, 0, 0, 1'b0);
    txn(1'b1, 16'h8123, 16'h00AA, 16'h0000, 1'b0, 1'b0, 2, 3, 16'h0123, 0, 1, 1'b0);
    kbd_valid = 1'b1; kbd_rdata = 16'h0041;
    txn(1'b0, 16'hFE00, 16'h0000, 16'h0041, 1'b0, 1'b1, 2, 0, 16'h0000, 0, 0, 1'b0);
    kbd_valid = 1'b0;
    txn(1'b0, 16'hFE00, 16'h0000, 16'h0000, 1'b0, 1'b0, 2, 0, 16'h0000, 0, 0, 1'b0);
    txn(1'b1, 16'hFF10, 16'h1111, 16'h0000, 1'b1, 1'b0, 1, 2, 16'hFFFF, 0, 0, 1'b0);
    txn(1'b0, 16'h8A00, 16'h0000, 16'h0000, 1'b1, 1'b0, 1, 3, 16'h3FFF, 0, 0, 1'b0);
    txn(1'b0, 16'hFE01, 16'h0000, 16'h0000, 1'b1, 1'b0, 1, 1, 16'hFFFF, 0, 0, 1'b0);
    ram_rdata = 16'h1234;
    txn(1'b0, 16'h7FFF, 16'h0000, 16'h1234, 1'b0, 1'b0, 3, 1, 16'h3FFF, 0, 0, 1'b0);
    txn(1'b0, 16'hFFFF, 16'h0000, 16'hC0FF, 1'b0, 1'b0, 2, 2, 16'h00FF, 0, 0, 1'b0);
    txn(1'b1, 16'h0100, 16'h5A5A, 16'h0000, 1'b0, 1'b0, 3, 1, 16'h0080, 1, 0, 1'b0);
    txn(1'b0, 16'h8000, 16'h0000, 16'h0000, 1'b0, 1'b0, 2, 3, 16'h0000, 0, 0, 1'b0);
    txn(1'b1, 16'h89FF, 16'h0F0F, 16'h0000, 1'b0, 1'b0, 2, 3, 16'h09FF, 0, 1, 1'b0);
    kbd_valid = 1'b1; kbd_rdata = 16'h0042;
    txn(1'b1, 16'hFE00, 16'h7777, 16'h0000, 1'b0, 1'b0, 2, 0, 16'h0000, 0, 0, 1'b0);
    kbd_valid = 1'b0;
    // back-to-back ROM reads with req held high through RESP
    txn(1'b0, 16'hFF00, 16'h0000, 16'hC000, 1'b0, 1'b0, 2, 2, 16'h0000, 0, 0, 1'b1);
    txn(1'b0, 16'hFF01, 16'h0000, 16'hC001, 1'b0, 1'b0, 2, 2, 16'h0001, 0, 0, 1'b0);

    reset_test();

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
- Sequential successor to the CPU's combinational address decoder.
- Accepts one CPU bus transaction at a time (req/ready handshake) and decodes the 16-bit virtual address into RAM, ROM, graphic or keyboard space.
- Applies per-region wait states, performs reads and writes, and returns registered read data.
- Flags unmapped accesses and ROM writes as bus errors. Sits between the CPU core and the memory/peripheral devices.

Parameters:
- DATA_W, 16, width of data buses.
- RAM_WAIT, 1, extra ACCESS cycles for RAM (0..15).
- ROM_WAIT, 0, extra ACCESS cycles for ROM (0..15).
- GFX_WAIT, 0, extra ACCESS cycles for graphic space (0..15).
- GFX_LO, 8'h80, first high byte of graphic window (inclusive).
- GFX_HI, 8'h8A, end high byte of graphic window (exclusive).
- KBD_ADDR, 16'hFE00, single keyboard data address.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- cpu_req  in  1  transaction request
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  16  virtual byte address
- cpu_wdata  in  DATA_W  write data
- cpu_ready  out  1  one-cycle completion pulse
- cpu_err  out  1  bus error, valid with cpu_ready
- cpu_rdata  out  DATA_W  read data, valid with cpu_ready
- ram_addr  out  16  RAM word address
- ram_en  out  1  RAM select
- ram_we  out  1  RAM write strobe
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data
- rom_addr  out  16  ROM address
- rom_rdata  in  DATA_W  ROM read data
- gfx_addr  out  14  graphic address
- gfx_we  out  1  graphic write strobe
- gfx_wdata  out  DATA_W  graphic write data
- kbd_rdata  in  DATA_W  keyboard head data
- kbd_valid  in  1  keyboard data available
- kbd_pop  out  1  consume keyboard data

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high.
- Reset values:
  - FSM in IDLE.
  - cpu_ready, cpu_err, ram_en, ram_we, gfx_we and kbd_pop are 0.
  - cpu_rdata is 0.
  - ram_addr and rom_addr are 16'hFFFF; gfx_addr is 14'h3FFF.
  - All device address outputs return to these idle values whenever the FSM is not in ACCESS.
- Decode, first match wins:
  - RAM: addr[15]==0. Word address = addr>>1.
  - ROM: addr[15:8]==8'hFF. Address = {8'h00, addr[7:0]}.
  - GFX: GFX_LO <= addr[15:8] < GFX_HI. Address = addr[13:0].
  - KBD: addr==KBD_ADDR.
  - Anything else is UNMAPPED.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - When cpu_req=1, latch addr, we and wdata, and decode the region.
  - If the region is UNMAPPED, or the access is a ROM write: go to RESP with err=1.
  - Otherwise load wait_cnt with the region's WAIT (KBD uses 0) and go to ACCESS.
- ACCESS:
  - Device address and ram_en are held stable for the whole state.
  - Write strobes (ram_we or gfx_we) are high in the first ACCESS cycle only.
  - While wait_cnt != 0, decrement it.
  - When wait_cnt == 0, capture read data into cpu_rdata and go to RESP:
    - RAM: ram_rdata. ROM: rom_rdata.
    - GFX: 0 (graphic space is write-only; reads return 0 with no error).
    - KBD: kbd_rdata if kbd_valid, else 0.
  - Writes set cpu_rdata to 0.
- RESP:
  - cpu_ready=1 for exactly one cycle, with cpu_err as decoded.
  - kbd_pop=1 in this cycle iff the access was a KBD read and kbd_valid was 1 at capture.
  - A KBD write is accepted and discarded, with no error.
  - Next state is IDLE.
- Latency:
  - Mapped access: cpu_ready in cycle WAIT+2 after the accepting cycle (cycle 0).
  - Error response: cpu_ready in cycle 1.
- Handshake:
  - The CPU holds req, we, addr and wdata stable until cpu_ready.
  - cpu_req is ignored outside IDLE.
  - A req still high in the RESP cycle is treated as a new request, accepted in the following IDLE cycle. Minimum spacing between transactions is 1 idle cycle.
- Reset mid-transaction: return to IDLE on the next edge. No cpu_ready, no strobes, no kbd_pop. The in-flight transaction is dropped.
- Boundary addresses:
  - 16'h7FFF goes to RAM, word address 16'h3FFF.
  - GFX_HI<<8 (16'h8A00) is UNMAPPED.
  - 16'hFE01 is UNMAPPED.
  - 16'hFFFF goes to ROM, address 16'h00FF.

Decomposition:
- Shared package mem_bus_pkg: region enum (REG_RAM, REG_KBD, REG_ROM, REG_GFX, REG_NONE), FSM state enum, and default address-map constants.
- One sub-module, addr_region_decode: combinational address to region plus translated addresses. Reused by the future MMU.

Test Plan:
- Read 16'h0010 with RAM_WAIT=1, ram_rdata=16'hBEEF → ram_addr=16'h0008 during ACCESS; cpu_ready in cycle 3; cpu_rdata=16'hBEEF; cpu_err=0.
- Write 16'h8123 with data 16'h00AA → gfx_we pulses once with gfx_addr=14'h0123, gfx_wdata=16'h00AA; cpu_ready in cycle 2.
- Read 16'hFE00 with kbd_valid=1, kbd_rdata=16'h0041 → cpu_rdata=16'h0041; kbd_pop=1 coincident with cpu_ready. Repeat with kbd_valid=0 → cpu_rdata=0, no pop.
- Write 16'hFF10, then read 16'h8A00 → both give cpu_ready with cpu_err=1 in cycle 1; no device strobes.
- Assert rst during ACCESS of a RAM read with RAM_WAIT=3 → no cpu_ready. After reset, outputs are at reset values and the next request completes normally.
- Hold cpu_req high for back-to-back reads of 16'hFF00 and 16'hFF01 → two cpu_ready pulses separated by one IDLE cycle, with rom_addr 16'h0000 and then 16'h0001.
